// File: rtl/drive_sequencer_pkg.sv
// Shared drive codes and channel state encoding for the drive sequencer.
package drive_sequencer_pkg;

  typedef logic [1:0] drive_code_t;

  localparam drive_code_t DRV_STOP = 2'd0;
  localparam drive_code_t DRV_HALF = 2'd1;
  localparam drive_code_t DRV_FAST = 2'd2;
  localparam drive_code_t DRV_REV  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEAD = 3'd1,
    ST_FWD1 = 3'd2,
    ST_FWD2 = 3'd3,
    ST_REV  = 3'd4
  } drive_state_e;

  // Drive code presented to the PWM generator for each state.
  function automatic drive_code_t drive_of(drive_state_e s);
    drive_code_t code;
    case (s)
      ST_FWD1: code = DRV_HALF;
      ST_FWD2: code = DRV_FAST;
      ST_REV:  code = DRV_REV;
      default: code = DRV_STOP;
    endcase
    return code;
  endfunction

  // Where a stopped channel goes for a given command. Code 2 must ramp
  // through code 1 first.
  function automatic drive_state_e idle_next(drive_code_t cmd);
    drive_state_e s;
    case (cmd)
      DRV_HALF: s = ST_FWD1;
      DRV_FAST: s = ST_FWD1;
      DRV_REV:  s = ST_REV;
      default:  s = ST_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/drive_sequencer_if.sv
// Command/drive bundle between the movement system and the sequencer.
interface drive_sequencer_if;
  import drive_sequencer_pkg::*;

  logic        TICK;
  logic        ESTOP;
  drive_code_t CmdA;
  drive_code_t CmdB;
  drive_code_t DriveA;
  drive_code_t DriveB;
  logic        SettledA;
  logic        SettledB;

  modport master (
    output TICK, ESTOP, CmdA, CmdB,
    input  DriveA, DriveB, SettledA, SettledB
  );

  modport slave (
    input  TICK, ESTOP, CmdA, CmdB,
    output DriveA, DriveB, SettledA, SettledB
  );

endinterface

// File: rtl/drive_sequencer_channel.sv
// One motor channel: soft-start ramp, reversal/stop dead-time, emergency stop.
//
//  state | meaning
//  IDLE  | stopped, drive 0, ready to start on the next tick
//  DEAD  | forced drive 0 for DEADTIME ticks, cannot be aborted
//  FWD1  | forward 50%, also the soft-start ramp stage
//  FWD2  | forward 75%
//  REV   | reverse 50%
module drive_channel
  import drive_sequencer_pkg::*;
#(
  parameter int DEADTIME = 8,
  parameter int RAMP     = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        tick_i,
  input  logic        estop_i,
  input  drive_code_t cmd_i,
  output drive_code_t drive_o,
  output logic        settled_o
);

  localparam logic [7:0] DEAD_LOAD = 8'(DEADTIME - 1);
  localparam logic [7:0] RAMP_LOAD = 8'(RAMP - 1);

  drive_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  drive_code_t  drive_q;
  logic         settled_q;
  drive_state_e start_s;

  assign start_s = idle_next(cmd_i);

  // Next-state and counter: ESTOP overrides everything, otherwise only ticks move.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (estop_i) begin
      state_d = ST_DEAD;
      cnt_d   = DEAD_LOAD;
    end else if (tick_i) begin
      case (state_q)
        ST_IDLE: begin
          state_d = start_s;
          cnt_d   = (start_s == ST_FWD1) ? RAMP_LOAD : 8'd0;
        end
        ST_FWD1: begin
          if (cmd_i == DRV_FAST) begin
            if (cnt_q == 8'd0) state_d = ST_FWD2;
            else               cnt_d   = cnt_q - 8'd1;
          end else if (cmd_i != DRV_HALF) begin
            state_d = ST_DEAD;
            cnt_d   = DEAD_LOAD;
          end
        end
        ST_FWD2: begin
          if (cmd_i == DRV_HALF) begin
            // deceleration is immediate, no dead-time
            state_d = ST_FWD1;
            cnt_d   = RAMP_LOAD;
          end else if (cmd_i != DRV_FAST) begin
            state_d = ST_DEAD;
            cnt_d   = DEAD_LOAD;
          end
        end
        ST_REV: begin
          if (cmd_i != DRV_REV) begin
            state_d = ST_DEAD;
            cnt_d   = DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            state_d = start_s;
            cnt_d   = (start_s == ST_FWD1) ? RAMP_LOAD : 8'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      drive_q   <= DRV_STOP;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drive_q   <= drive_of(state_d);
      settled_q <= (drive_of(state_d) == cmd_i) && (state_d != ST_DEAD);
    end
  end

  assign drive_o   = drive_q;
  assign settled_o = settled_q;

endmodule

// File: rtl/drive_sequencer.sv
// Two independent drive channels (A, B) feeding the PWM generator.
module drive_sequencer #(
  parameter int DEADTIME = 8,
  parameter int RAMP     = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  drive_sequencer_if.slave bus
);

  drive_channel #(.DEADTIME(DEADTIME), .RAMP(RAMP)) u_chan_a (
    .clk_i     (CLK),
    .rst_n_i   (RST_N),
    .tick_i    (bus.TICK),
    .estop_i   (bus.ESTOP),
    .cmd_i     (bus.CmdA),
    .drive_o   (bus.DriveA),
    .settled_o (bus.SettledA)
  );

  drive_channel #(.DEADTIME(DEADTIME), .RAMP(RAMP)) u_chan_b (
    .clk_i     (CLK),
    .rst_n_i   (RST_N),
    .tick_i    (bus.TICK),
    .estop_i   (bus.ESTOP),
    .cmd_i     (bus.CmdB),
    .drive_o   (bus.DriveB),
    .settled_o (bus.SettledB)
  );

endmodule
